// File: rtl/btn_pkg.sv
// Shared defaults, the output-slot state type and the id-width helper for
// the button event arbiter.
package btn_pkg;

  localparam int N_BTN_DEF      = 4;
  localparam int DEB_CYCLES_DEF = 16;
  localparam int DROP_W_DEF     = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } slot_e;

  // Number of bits needed to hold a channel index 0..n-1 (minimum 1).
  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, optional debounce counter
// (enabled by the macro BTN_DEBOUNCE_EN) and a rising-edge detector that
// emits a single-cycle press pulse.
module btn_channel
  import btn_pkg::*;
`ifdef BTN_DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
)
`endif
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic prev_q;

  // Two-flop synchronizer for the raw asynchronous button level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             deb_q;
  logic             deb_d;

  // Count consecutive cycles of disagreement; any bounce restarts the count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce counter and filtered level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  // Edge history: the filtered level delayed by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  // Only press (rising) edges matter; releases are ignored.
  assign press_o = level & ~prev_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: turns N raw button lines into one ordered stream of
// press events on a valid/ready interface, round-robin between channels.
// Optional debounce filtering is enabled by defining BTN_DEBOUNCE_EN.
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int ID_W       = id_width(N_BTN),
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DROP_W     = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [N_BTN-1:0]  pending,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_drop
);

  if (N_BTN < 2 || N_BTN > 16 || ID_W != id_width(N_BTN) || DEB_CYCLES < 1) begin : g_param_chk
    $error("button_event_arbiter: illegal parameter combination");
  end

  logic [N_BTN-1:0]  press;
  logic [N_BTN-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  slot_e             state_q, state_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   win_next;
  logic              grant;
  logic [N_BTN-1:0]  gnt_vec;
  logic [N_BTN-1:0]  keep_vec;
  logic [N_BTN-1:0]  drop_vec;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
`ifdef BTN_DEBOUNCE_EN
    btn_channel #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (btn_in[g]),
      .press_o(press[g])
    );
`else
    btn_channel u_ch (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (btn_in[g]),
      .press_o(press[g])
    );
`endif
  end

  // Round-robin search: first pending bit at or above rr_q, then wrap to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!win_found && pending_q[i] && (i >= int'(rr_q))) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (!win_found && pending_q[i] && (i < int'(rr_q))) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
    win_next = (int'(win_idx) == N_BTN - 1) ? '0 : win_idx + 1'b1;
  end

  // Output-slot FSM: load a winner when the slot is empty or being accepted.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (evt_ready) begin
          if (win_found) begin
            grant = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (grant) begin
      id_d = win_idx;
      rr_d = win_next;
    end
  end

  // Pending flags and drop counting; a press on the granted channel re-pends.
  always_comb begin
    gnt_vec = '0;
    if (grant) begin
      gnt_vec[win_idx] = 1'b1;
    end
    keep_vec  = pending_q & ~gnt_vec;
    pending_d = keep_vec | press;
    drop_vec  = keep_vec & press;
    drop_d    = drop_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (drop_vec[i]) begin
        drop_d = sat_inc(drop_d);
      end
    end
    if (clr_drop) begin
      drop_d = '0;
    end
  end

  // State registers; reset discards the presented event and all pending ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign evt_valid = (state_q == S_HOLD);
  assign evt_id    = id_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: a per-cycle vector table for the
// main sequences, plus hand-written reset and debounce sequences.
module tb_button_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic [7:0] drop_cnt;
  logic       clr_drop;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic       rstn;
    logic [3:0] btn;
    logic       rdy;
    logic       clr;
    logic       vld;
    logic [1:0] id;
    logic [3:0] pend;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl[$];

  button_event_arbiter #(
    .N_BTN     (4),
    .ID_W      (2),
    .DEB_CYCLES(4),
    .DROP_W    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .pending  (pending),
    .drop_cnt (drop_cnt),
    .clr_drop (clr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rstn, input logic [3:0] btn, input logic rdy,
                              input logic clr, input logic vld, input logic [1:0] id,
                              input logic [3:0] pend, input logic [7:0] drop);
    vec_t v;
    v.rstn = rstn; v.btn = btn; v.rdy = rdy; v.clr = clr;
    v.vld = vld; v.id = id; v.pend = pend; v.drop = drop;
    return v;
  endfunction

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    btn_in    = 4'b0000;
    evt_ready = 1'b0;
    clr_drop  = 1'b0;
    #1;
    check("reset_valid", 32'(evt_valid), 32'd0);
    check("reset_id", 32'(evt_id), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);
    step();
    step();
    rst_n = 1'b1;

`ifndef BTN_DEBOUNCE_EN
    // Single press on channel 2 with the consumer always ready.
    tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 0, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 1, 2, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
    // Reset to restart the round-robin pointer, then press 0,1,3 together.
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 0, 0, 4'b1011, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 1, 0, 4'b1010, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 0, 1, 0, 4'b1010, 0));
    tbl.push_back(mk(1, 4'b1011, 1, 0, 1, 1, 4'b1000, 0));
    tbl.push_back(mk(1, 4'b1011, 1, 0, 1, 3, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1011, 1, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
    // Coalescing: slot busy with channel 0, channel 1 pressed twice.
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 0, 1, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 0, 1, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 0, 1, 0, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 0, 1, 0, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 0, 1, 0, 4'b0010, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 0, 1, 1, 4'b0000, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 0, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 1, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));
    // Re-press of channel 0 aligned with the cycle its pending bit is granted.
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 1, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0001, 1, 0, 1, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 1, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n     = tbl[i].rstn;
      btn_in    = tbl[i].btn;
      evt_ready = tbl[i].rdy;
      clr_drop  = tbl[i].clr;
      step();
      check($sformatf("v%0d_valid", i), 32'(evt_valid), 32'(tbl[i].vld));
      check($sformatf("v%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
      check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
      if (tbl[i].vld) begin
        check($sformatf("v%0d_id", i), 32'(evt_id), 32'(tbl[i].id));
      end
    end

    // Reset mid-handshake with evt_valid=1 and pending=1010.
    rst_n = 1'b0;
    btn_in = 4'b0000;
    evt_ready = 1'b0;
    step();
    rst_n = 1'b1;
    btn_in = 4'b1011;
    for (int i = 0; i < 4; i++) step();
    check("rst_setup_valid", 32'(evt_valid), 32'd1);
    check("rst_setup_pending", 32'(pending), 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(evt_valid), 32'd0);
    check("rst_async_pending", 32'(pending), 32'd0);
    check("rst_async_drop", 32'(drop_cnt), 32'd0);
    check("rst_async_id", 32'(evt_id), 32'd0);
    btn_in = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rst_after_valid", 32'(evt_valid), 32'd0);
    check("rst_after_pending", 32'(pending), 32'd0);
`else
    // 3-cycle glitch on channel 1 must be filtered out.
    evt_ready = 1'b0;
    btn_in = 4'b0010;
    for (int i = 0; i < 3; i++) step();
    btn_in = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("glitch_valid_%0d", i), 32'(evt_valid), 32'd0);
      check($sformatf("glitch_pending_%0d", i), 32'(pending), 32'd0);
    end
    // Level held 6 cycles: first sampled at edge k, event visible after k+7.
    btn_in = 4'b0010;
    for (int e = 0; e <= 7; e++) begin
      if (e == 6) btn_in = 4'b0000;
      step();
      check($sformatf("held_valid_e%0d", e), 32'(evt_valid), (e == 7) ? 32'd1 : 32'd0);
    end
    check("held_id", 32'(evt_id), 32'd1);
    check("held_pending", 32'(pending), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
